// File: rtl/block_ram_mw_ctrl.sv
// Load/read controller for a block RAM holding NUM_WORDS lanes per row: a serial
// loader that fills lanes LSB-first, and a read front-end with a fixed-latency response pipe.
module block_ram_mw_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned NUM_WORDS       = 4,
    parameter string       OUTPUT_REGISTER = "false",
    localparam int unsigned AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [AW-1:0]         ram_wr_addr,
    output logic [NUM_WORDS-1:0]  ram_wr_en,
    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_req_addr,
    output logic                  rd_req_ready,
    output logic                  ram_rd_en,
    output logic [AW-1:0]         ram_rd_addr,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  load_done,
    output logic                  busy
);

    localparam int unsigned LW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned LAT = (OUTPUT_REGISTER == "true") ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [AW-1:0]   row_q, row_d;
    logic            load_done_q, load_done_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [LAT-1:0]  err_q, err_d;

    logic            load_beat_c;
    logic            last_lane_c;
    logic            last_row_c;
    logic            rd_acc_c;
    logic            rd_in_range_c;

    // Address range check collapses to constant true when DEPTH fills the address space.
    if (DEPTH == (1 << AW)) begin : g_full_range
        assign rd_in_range_c = 1'b1;
    end else begin : g_part_range
        localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
        assign rd_in_range_c = ({1'b0, rd_req_addr} < DEPTH_W);
    end

    always_comb begin
        load_beat_c = s_valid && (state_q == ST_LOAD);
        last_lane_c = (lane_q == LW'(NUM_WORDS - 1));
        last_row_c  = (row_q == AW'(DEPTH - 1));
        rd_acc_c    = rd_req && (state_q == ST_READY);
    end

    // Next-state, fill counters and response pipeline.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        row_d       = row_q;
        load_done_d = load_done_q;
        vld_d       = '0;
        err_d       = '0;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    lane_d      = '0;
                    row_d       = '0;
                    load_done_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_beat_c) begin
                    if (last_lane_c) begin
                        lane_d = '0;
                        if (last_row_c) begin
                            row_d       = '0;
                            state_d     = ST_READY;
                            load_done_d = 1'b1;
                        end else begin
                            row_d = row_q + AW'(1);
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Responses keep flowing across a READY->LOAD transition.
        vld_d[0] = rd_acc_c && rd_in_range_c;
        err_d[0] = rd_acc_c && !rd_in_range_c;
        for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            row_q       <= '0;
            load_done_q <= 1'b0;
            vld_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            row_q       <= row_d;
            load_done_q <= load_done_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
        end
    end

    // RAM-side strobes follow the handshakes in the same cycle.
    always_comb begin
        ram_wr_en   = '0;
        ram_wr_data = s_data;
        ram_wr_addr = row_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        if (load_beat_c) begin
            ram_wr_en = NUM_WORDS'(1) << lane_q;
        end
        if (rd_acc_c && rd_in_range_c) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = rd_req_addr;
        end
    end

    assign s_ready      = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD);
    assign rd_req_ready = (state_q == ST_READY);
    assign load_done    = load_done_q;
    assign rd_valid     = vld_q[LAT-1];
    assign rd_err       = err_q[LAT-1];

endmodule

// File: doc/block_ram_mw_ctrl.md
BLOCK_RAM_MW_CTRL -- requirements
Module: block_ram_mw_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one word.
REQ-002 SHALL have parameter DEPTH, default 64, number of RAM rows.
REQ-003 SHALL have parameter NUM_WORDS, default 4, words per row.
REQ-004 SHALL have parameter OUTPUT_REGISTER, default "false", RAM output register setting; "true" gives read latency 2, "false" gives 1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  single-cycle pulse that begins a full load of DEPTH*NUM_WORDS words.
REQ-009 s_data  input  DATA_WIDTH  load word.
REQ-010 s_valid  input  1  load word valid.
REQ-011 s_ready  output  1  controller accepts load word.
REQ-012 ram_wr_data  output  DATA_WIDTH  RAM write data.
REQ-013 ram_wr_addr  output  clog2(DEPTH)  RAM write row.
REQ-014 ram_wr_en  output  NUM_WORDS  one-hot RAM lane write enable.
REQ-015 rd_req  input  1  read request valid.
REQ-016 rd_req_addr  input  clog2(DEPTH)  requested row.
REQ-017 rd_req_ready  output  1  read request accepted.
REQ-018 ram_rd_en  output  1  RAM read enable.
REQ-019 ram_rd_addr  output  clog2(DEPTH)  RAM read row.
REQ-020 rd_valid  output  1  RAM rd_data valid this cycle for an accepted request.
REQ-021 rd_err  output  1  accepted request was out of range; no data.
REQ-022 load_done  output  1  full image loaded, reads permitted.
REQ-023 busy  output  1  load in progress.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, READY: IDLE -start-> LOAD; LOAD -last word accepted-> READY; READY -start-> LOAD.
REQ-025 start SHALL be ignored while in LOAD.
REQ-026 s_ready SHALL be 1 only in LOAD; a load beat is s_valid & s_ready.
REQ-027 Entering LOAD SHALL clear lane counter and row counter to 0 and clear load_done.
REQ-028 On a load beat, ram_wr_en SHALL be one-hot at the lane counter (same cycle, combinational); ram_wr_data = s_data; ram_wr_addr = row counter; otherwise ram_wr_en = 0.
REQ-029 Fill order: lane 0 (LSB word) to NUM_WORDS-1 within a row, then row+1; lane wraps to 0 when the row increments.
REQ-030 The beat at lane NUM_WORDS-1, row DEPTH-1 SHALL be the last beat; the FSM enters READY on the following edge and load_done is 1 from that edge.
REQ-031 busy SHALL equal (state == LOAD).
REQ-032 rd_req_ready SHALL be 1 only in READY; an accepted read is rd_req & rd_req_ready.
REQ-033 For an accepted read with rd_req_addr < DEPTH: ram_rd_en = 1 and ram_rd_addr = rd_req_addr in the same cycle (combinational).
REQ-034 For an accepted read with rd_req_addr >= DEPTH: ram_rd_en = 0, and rd_err SHALL pulse in place of rd_valid.
REQ-035 rd_valid/rd_err SHALL assert exactly LAT cycles after acceptance (LAT = 1 or 2 per OUTPUT_REGISTER), one cycle per accepted read; back-to-back reads give back-to-back rd_valid.
REQ-036 Reads accepted before a READY->LOAD transition SHALL still produce their rd_valid/rd_err.
REQ-037 Requests in IDLE/LOAD SHALL not be accepted: ram_rd_en = 0, no response generated.
REQ-038 ram_rd_addr SHALL be 0 when ram_rd_en = 0; ram_wr_addr/ram_wr_data SHALL be don't-care when ram_wr_en = 0.

Reset
REQ-039 rst_n low SHALL immediately force state IDLE, counters 0, response pipeline cleared, s_ready=0, rd_req_ready=0, rd_valid=0, rd_err=0, load_done=0, busy=0, ram_wr_en=0, ram_rd_en=0.
REQ-040 Reset mid-load or with reads in flight SHALL drop them: no further write enables and no rd_valid after release.

Verification (DATA_WIDTH=8, DEPTH=4, NUM_WORDS=4 unless noted)
REQ-041 start, then 16 beats with s_data 0x00..0x0F, s_valid held high -> ram_wr_en 0001,0010,0100,1000 per row, rows 0..3; load_done=1 one cycle after the 16th beat; row 2 reads 0x0B0A0908.
REQ-042 Load with s_valid toggling every other cycle -> exactly 16 write enables, none on s_valid=0 cycles; busy high throughout.
REQ-043 In READY, rd_req on addresses 3,1,0 on consecutive cycles, OUTPUT_REGISTER "false" -> rd_valid for 3 cycles starting 1 cycle after the first request; with "true", starting 2 cycles after.
REQ-044 DEPTH=6, rd_req_addr=7 in READY -> ram_rd_en=0, rd_err=1 after LAT, rd_valid=0.
REQ-045 rd_req during LOAD and a second start at beat 5 -> rd_req_ready=0, no ram_rd_en, lane/row counters unaffected.
REQ-046 rst_n low after beat 9 with a read in flight -> all outputs at reset values immediately; after release, no rd_valid and load_done=0 until a new full load completes.
